// File: rtl/axi_rd_burst_ctrl.sv
// Read-burst sequencer for axi_master_rd: walks a circular DDR3 region in 4 KB-safe
// INCR bursts, gates issue on FIFO room, forwards beats and checks per-burst beat counts.
module axi_rd_burst_ctrl #(
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [29:0]      rd_base_addr,
    input  logic [29:0]      rd_end_addr,
    input  logic [8:0]       rd_burst_beats,
    input  logic             rd_addr_rst,
    input  logic [CNT_W-1:0] rd_fifo_wr_cnt,
    input  logic             rd_ready,
    input  logic             rd_done,
    input  logic [63:0]      rd_data,
    input  logic             m_axi_r_handshake,
    output logic             rd_start,
    output logic [29:0]      rd_addr,
    output logic [7:0]       rd_len,
    output logic             rd_fifo_wr_en,
    output logic [63:0]      rd_fifo_wr_data,
    output logic             rd_busy,
    output logic             rd_beat_err
);

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          pend_q, pend_d;
    logic          start_q, start_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [BW-1:0] cnt_q, cnt_d;

    logic [12:0]   room_c;
    logic [BW-1:0] cfg_c;
    logic [BW-1:0] beats_c;
    logic          space_ok_c;
    logic [AW:0]   nxt_c;
    logic          wrap_c;

    // Burst sizing: clamp config to 1..256, then stop at the next 4 KB line.
    always_comb begin
        room_c  = (13'd4096 - 13'(ptr_q[11:0])) >> 3;
        if (rd_burst_beats == 9'd0) begin
            cfg_c = 9'd1;
        end else if (rd_burst_beats > 9'd256) begin
            cfg_c = 9'd256;
        end else begin
            cfg_c = rd_burst_beats;
        end
        beats_c    = (13'(cfg_c) < room_c) ? cfg_c : room_c[BW-1:0];
        space_ok_c = (32'(rd_fifo_wr_cnt) <= FIFO_DEPTH) &&
                     ((FIFO_DEPTH - 32'(rd_fifo_wr_cnt)) >= 32'(beats_c));
        nxt_c      = 31'(addr_q) + ((31'(len_q) + 31'd1) << 3);
        wrap_c     = (nxt_c >= 31'(rd_end_addr));
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        start_d = 1'b0;
        addr_d  = addr_q;
        len_d   = len_q;
        busy_d  = busy_q;
        err_d   = err_q;
        cnt_d   = m_axi_r_handshake ? (cnt_q + 9'd1) : cnt_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q || rd_addr_rst) begin
                    ptr_d  = rd_base_addr;
                    pend_d = 1'b0;
                end else if (rd_en && rd_ready && space_ok_c) begin
                    state_d = S_REQ;
                    start_d = 1'b1;
                    addr_d  = ptr_q;
                    len_d   = 8'(beats_c - 9'd1);
                    busy_d  = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = '0;
                if (rd_addr_rst) begin
                    pend_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (rd_addr_rst) begin
                    pend_d = 1'b1;
                end
                if (rd_done) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (cnt_d != (9'(len_q) + 9'd1)) begin
                        err_d = 1'b1;
                    end
                    // A pending or coincident pointer reset overrides the advance.
                    if (pend_q || rd_addr_rst) begin
                        ptr_d  = rd_base_addr;
                        pend_d = 1'b0;
                    end else if (wrap_c) begin
                        ptr_d = rd_base_addr;
                    end else begin
                        ptr_d = nxt_c[AW-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // pend_q comes out of reset set so the pointer loads rd_base_addr first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            pend_q  <= 1'b1;
            start_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rd_start    = start_q;
    assign rd_addr     = addr_q;
    assign rd_len      = len_q;
    assign rd_busy     = busy_q;
    assign rd_beat_err = err_q;

    // Pass-through beat path; held low during reset like every other output.
    assign rd_fifo_wr_en   = m_axi_r_handshake & rst_n;
    assign rd_fifo_wr_data = rd_data & {DW{rst_n}};

endmodule
